// File: rtl/icache_pkg.sv
// Shared types and address helpers for the L1 instruction cache.
// Address helpers work on a 64-bit view so any ADDR_W up to 64 can use them.
package icache_pkg;

    typedef enum logic [2:0] {IDLE, LOOKUP, BUS_REQ, FILL, RESPOND} state_t;

    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int age_width(input int ways);
        return $clog2(ways);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int index_w);
        return addr & ((64'd1 << index_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int index_w);
        return addr >> index_w;
    endfunction

endpackage

// File: rtl/icache_lru.sv
// True-LRU age array: one age per way per set, 0 = most recent, WAYS-1 = least recent.
// Reports the least-recently-used way of every set.
module icache_lru
    import icache_pkg::*;
#(
    parameter int SETS = 16,
    parameter int WAYS = 4,
    localparam int INDEX_W = index_width(SETS),
    localparam int AGE_W = age_width(WAYS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       upd_en,
    input  logic [INDEX_W-1:0]         upd_set,
    input  logic [AGE_W-1:0]           upd_way,
    output logic [SETS-1:0][AGE_W-1:0] lru_way
);

    logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age;
    logic [AGE_W-1:0]                     acc_age;

    assign acc_age = age[upd_set][upd_way];

    // Accessed way becomes youngest; only ways younger than it age by one,
    // so the set stays a permutation of 0..WAYS-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= AGE_W'(w);
        end else if (upd_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == upd_way)
                    age[upd_set][w] <= '0;
                else if (age[upd_set][w] < acc_age)
                    age[upd_set][w] <= age[upd_set][w] + 1'b1;
            end
        end
    end

    always_comb begin
        lru_way = '0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (age[s][w] == AGE_W'(WAYS - 1))
                    lru_way[s] = AGE_W'(w);
    end

endmodule

// File: rtl/icache_unit.sv
// Set-associative L1 instruction cache with snoop invalidation and hit/miss statistics.
// Lines are Shared or Invalid only; misses are filled one word at a time from the common bus.
module icache_unit
    import icache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SETS   = 16,
    parameter int WAYS   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_stall,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_data,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_rd,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              bus_data_valid,
    input  logic              inv_valid,
    input  logic [ADDR_W-1:0] inv_addr,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int INDEX_W = index_width(SETS);
    localparam int AGE_W   = age_width(WAYS);
    localparam int TAG_W   = ADDR_W - INDEX_W;

    state_t                    state;
    logic [ADDR_W-1:0]         req_addr;
    logic [AGE_W-1:0]          victim_way;
    logic                      inv_kill;
    logic [SETS-1:0][WAYS-1:0] valid;
    logic [TAG_W-1:0]          tag_mem  [SETS][WAYS];
    logic [DATA_W-1:0]         data_mem [SETS][WAYS];

    logic [INDEX_W-1:0]        req_idx, inv_idx;
    logic [TAG_W-1:0]          req_tag, inv_tag;
    logic                      inv_same, kill_now;
    logic                      hit, any_invalid;
    logic [AGE_W-1:0]          hit_way, free_way, victim_sel, lru_acc_way;
    logic [WAYS-1:0]           inv_match;
    logic                      lru_upd;
    logic [SETS-1:0][AGE_W-1:0] lru_way;

    assign req_idx = INDEX_W'(addr_index(64'(req_addr), INDEX_W));
    assign req_tag = TAG_W'(addr_tag(64'(req_addr), INDEX_W));
    assign inv_idx = INDEX_W'(addr_index(64'(inv_addr), INDEX_W));
    assign inv_tag = TAG_W'(addr_tag(64'(inv_addr), INDEX_W));

    // A snoop on the outstanding address masks a hit and blocks installing the fill.
    assign inv_same = inv_valid && (inv_addr == req_addr);
    assign kill_now = inv_kill || inv_same;

    // Descending scan so the lowest-index way wins for both the hit and the free slot.
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        any_invalid = 1'b0;
        free_way    = '0;
        inv_match   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
                hit     = !inv_same;
                hit_way = AGE_W'(w);
            end
            if (!valid[req_idx][w]) begin
                any_invalid = 1'b1;
                free_way    = AGE_W'(w);
            end
            inv_match[w] = valid[inv_idx][w] && (tag_mem[inv_idx][w] == inv_tag);
        end
    end

    assign victim_sel  = any_invalid ? free_way : lru_way[req_idx];
    assign lru_acc_way = (state == LOOKUP) ? hit_way : victim_way;
    assign lru_upd     = ((state == LOOKUP) && hit) ||
                         ((state == FILL) && bus_data_valid && !kill_now);

    icache_lru #(
        .SETS(SETS),
        .WAYS(WAYS)
    ) u_lru (
        .clk    (clk),
        .rst    (rst),
        .upd_en (lru_upd),
        .upd_set(req_idx),
        .upd_way(lru_acc_way),
        .lru_way(lru_way)
    );

    // Invalidation is applied first so a same-edge install into that set still takes effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= '0;
            victim_way <= '0;
            inv_kill   <= 1'b0;
            valid      <= '0;
            cpu_stall  <= 1'b0;
            cpu_valid  <= 1'b0;
            cpu_data   <= '0;
            bus_req    <= 1'b0;
            bus_rd     <= 1'b0;
            bus_addr   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            cpu_valid <= 1'b0;
            if (inv_valid)
                valid[inv_idx] <= valid[inv_idx] & ~inv_match;
            case (state)
                IDLE: begin
                    inv_kill <= 1'b0;
                    if (cpu_rd) begin
                        req_addr  <= cpu_addr;
                        cpu_stall <= 1'b1;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        cpu_data  <= data_mem[req_idx][hit_way];
                        cpu_valid <= 1'b1;
                        if (hit_count != '1)
                            hit_count <= hit_count + 1'b1;
                        state <= RESPOND;
                    end else begin
                        victim_way <= victim_sel;
                        bus_req    <= 1'b1;
                        if (miss_count != '1)
                            miss_count <= miss_count + 1'b1;
                        state <= BUS_REQ;
                    end
                end
                BUS_REQ: begin
                    if (inv_same)
                        inv_kill <= 1'b1;
                    if (bus_gnt) begin
                        bus_rd   <= 1'b1;
                        bus_addr <= req_addr;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (inv_same)
                        inv_kill <= 1'b1;
                    if (bus_data_valid) begin
                        cpu_data  <= bus_data;
                        cpu_valid <= 1'b1;
                        bus_req   <= 1'b0;
                        bus_rd    <= 1'b0;
                        bus_addr  <= '0;
                        if (!kill_now) begin
                            tag_mem[req_idx][victim_way]  <= req_tag;
                            data_mem[req_idx][victim_way] <= bus_data;
                            valid[req_idx][victim_way]    <= 1'b1;
                        end
                        state <= RESPOND;
                    end
                end
                RESPOND: begin
                    cpu_stall <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The arbiter must hold the grant for the whole fill.
    property p_gnt_held_in_fill;
        @(posedge clk) disable iff (rst) (state == FILL) |-> bus_gnt;
    endproperty
    assert property (p_gnt_held_in_fill);

endmodule

// File: tb/tb_icache_unit.sv
// Self-checking bench for icache_unit: directed scenarios plus randomized reads
// compared against a timestamp-based LRU cache model.
module tb_icache_unit;

    localparam int SETS  = 16;
    localparam int WAYS  = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             cpu_rd;
    logic [31:0]      cpu_addr;
    logic             cpu_stall;
    logic             cpu_valid;
    logic [31:0]      cpu_data;
    logic             bus_req;
    logic             bus_gnt;
    logic             bus_rd;
    logic [31:0]      bus_addr;
    logic [31:0]      bus_data;
    logic             bus_data_valid;
    logic             inv_valid;
    logic [31:0]      inv_addr;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    int checks   = 0;
    int failures = 0;

    icache_unit #(
        .ADDR_W(32), .DATA_W(32), .SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_rd        (cpu_rd),
        .cpu_addr      (cpu_addr),
        .cpu_stall     (cpu_stall),
        .cpu_valid     (cpu_valid),
        .cpu_data      (cpu_data),
        .bus_req       (bus_req),
        .bus_gnt       (bus_gnt),
        .bus_rd        (bus_rd),
        .bus_addr      (bus_addr),
        .bus_data      (bus_data),
        .bus_data_valid(bus_data_valid),
        .inv_valid     (inv_valid),
        .inv_addr      (inv_addr),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    // Reference model: per-line valid/tag/data plus a last-use timestamp; the LRU line
    // is simply the one with the oldest timestamp.
    logic [27:0] m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS];
    bit          m_valid [SETS][WAYS];
    int          m_stamp [SETS][WAYS];
    int          m_now, m_hits, m_misses;

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_stamp[s][w] = -w;
            end
        m_now = 0; m_hits = 0; m_misses = 0;
    endfunction

    function automatic int model_find(logic [31:0] a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[a[3:0]][w] && m_tag[a[3:0]][w] == a[31:4]) return w;
        return -1;
    endfunction

    function automatic int model_victim(int s);
        int best = 0;
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[s][w]) return w;
        for (int w = 1; w < WAYS; w++)
            if (m_stamp[s][w] < m_stamp[s][best]) best = w;
        return best;
    endfunction

    function automatic void model_inv(logic [31:0] a);
        int w = model_find(a);
        if (w >= 0) m_valid[a[3:0]][w] = 0;
    endfunction

    function automatic void model_read(input logic [31:0] a, input logic [31:0] fill, input bit kill,
                                       output logic [31:0] exp_data, output logic exp_miss);
        int s = int'(a[3:0]);
        int w = model_find(a);
        if (w >= 0) begin
            exp_data = m_data[s][w]; exp_miss = 1'b0;
            if (m_hits < CMAX) m_hits++;
            m_now++; m_stamp[s][w] = m_now;
        end else begin
            exp_data = fill; exp_miss = 1'b1;
            if (m_misses < CMAX) m_misses++;
            if (!kill) begin
                w = model_victim(s);
                m_valid[s][w] = 1; m_tag[s][w] = a[31:4]; m_data[s][w] = fill;
                m_now++; m_stamp[s][w] = m_now;
            end
        end
    endfunction

    task automatic do_reset();
        cpu_rd = 0; bus_gnt = 0; bus_data_valid = 0; inv_valid = 0; rst = 1;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    task automatic snoop(input logic [31:0] a);
        inv_valid = 1; inv_addr = a;
        @(posedge clk); #1;
        inv_valid = 0;
    endtask

    // Issues one fetch from IDLE and plays the arbiter/memory side.
    // inv_mode: 0 none, 1 snoop same address on the data beat, 2 snoop during the first bus_req cycle.
    // lat counts edges from the accepting edge to the edge that samples cpu_valid.
    task automatic cpu_read(input logic [31:0] addr, input int gnt_wait, input logic [31:0] fill,
                            input int inv_mode, output logic [31:0] rdata, output logic miss,
                            output logic [31:0] saddr, output int lat, output logic timeout);
        int waited = 0;
        bit inv_done = 0;
        rdata = '0; miss = 0; saddr = '0; lat = 0; timeout = 1;
        cpu_addr = addr; cpu_rd = 1;
        @(posedge clk); #1;
        cpu_rd = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cpu_valid) begin
                rdata = cpu_data; lat = cyc + 1; timeout = 0;
                break;
            end
            if (bus_req) begin
                miss = 1;
                if (inv_mode == 2 && !inv_done) begin
                    inv_valid = 1; inv_addr = addr; inv_done = 1;
                end
                if (!bus_gnt) begin
                    if (waited >= gnt_wait) bus_gnt = 1;
                    else waited++;
                end
            end
            if (bus_rd) begin
                saddr = bus_addr; bus_data = fill; bus_data_valid = 1;
                if (inv_mode == 1) begin
                    inv_valid = 1; inv_addr = addr;
                end
            end
            @(posedge clk); #1;
            bus_data_valid = 0; inv_valid = 0;
        end
        bus_gnt = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        cpu_rd = 1; cpu_addr = 32'h13; bus_gnt = 0; bus_data_valid = 0; inv_valid = 0;
        bus_data = '0; inv_addr = '0; rst = 1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({cpu_stall, cpu_valid, bus_req, bus_rd} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: stall/valid/req/rd=%b expected 0000", {cpu_stall, cpu_valid, bus_req, bus_rd});
        end
        checks++;
        if ({cpu_data, bus_addr, hit_count, miss_count} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: cpu_data=%h bus_addr=%h hits=%0d misses=%0d expected all 0",
                     cpu_data, bus_addr, hit_count, miss_count);
        end
        cpu_rd = 0; rst = 0;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if (cpu_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle_stall: got %b expected 0", cpu_stall);
        end
    endtask

    task automatic test_cold_miss_then_hit();
        logic [31:0] rdata, saddr;
        logic miss, timeout;
        int lat;
        do_reset();
        cpu_read(32'h13, 3, 32'hDEADBEEF, 0, rdata, miss, saddr, lat, timeout);
        checks++;
        if (timeout || miss !== 1'b1 || saddr !== 32'h13) begin
            failures++;
            $display("[TB] FAIL cold_bus: timeout=%b miss=%b bus_addr=%h expected 0/1/00000013", timeout, miss, saddr);
        end
        checks++;
        if (rdata !== 32'hDEADBEEF || lat != 7) begin
            failures++;
            $display("[TB] FAIL cold_data: data=%h lat=%0d expected deadbeef/7", rdata, lat);
        end
        checks++;
        if (miss_count !== 4'd1 || bus_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL cold_count: misses=%0d bus_addr=%h expected 1/0", miss_count, bus_addr);
        end
        cpu_read(32'h13, 0, 32'h11111111, 0, rdata, miss, saddr, lat, timeout);
        checks++;
        if (timeout || miss !== 1'b0 || lat != 2 || rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL rehit: timeout=%b busreq=%b lat=%0d data=%h expected 0/0/2/deadbeef", timeout, miss, lat, rdata);
        end
        checks++;
        if (hit_count !== 4'd1) begin
            failures++;
            $display("[TB] FAIL rehit_count: got %0d expected 1", hit_count);
        end
    endtask

    task automatic test_lru();
        logic [31:0] rdata, saddr;
        logic [31:0] seq   [8] = '{32'h03, 32'h13, 32'h23, 32'h33, 32'h03, 32'h43, 32'h13, 32'h03};
        logic        emiss [8] = '{1, 1, 1, 1, 0, 1, 1, 0};
        logic miss, timeout;
        int lat;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cpu_read(seq[i], 0, 32'hA0000000 | seq[i], 0, rdata, miss, saddr, lat, timeout);
            checks++;
            if (timeout || miss !== emiss[i] || rdata !== (32'hA0000000 | seq[i])) begin
                failures++;
                $display("[TB] FAIL lru_step%0d: addr=%h miss=%b data=%h expected miss=%b data=%h",
                         i, seq[i], miss, rdata, emiss[i], 32'hA0000000 | seq[i]);
            end
        end
        cpu_read(32'h33, 0, 32'h0, 0, rdata, miss, saddr, lat, timeout);
        checks++;
        if (miss !== 1'b0 || rdata !== 32'hA0000033) begin
            failures++;
            $display("[TB] FAIL lru_keep33: miss=%b data=%h expected 0/a0000033", miss, rdata);
        end
    endtask

    task automatic test_snoop();
        logic [31:0] rdata, saddr;
        logic miss, timeout;
        int lat;
        do_reset();
        cpu_read(32'h23, 0, 32'h23232323, 0, rdata, miss, saddr, lat, timeout);
        snoop(32'h23);
        cpu_read(32'h23, 1, 32'h23000001, 0, rdata, miss, saddr, lat, timeout);
        checks++;
        if (miss !== 1'b1 || saddr !== 32'h23 || rdata !== 32'h23000001) begin
            failures++;
            $display("[TB] FAIL snoop_inv: miss=%b bus_addr=%h data=%h expected 1/23/23000001", miss, saddr, rdata);
        end
        snoop(32'h73);
        cpu_read(32'h23, 0, 32'h0, 0, rdata, miss, saddr, lat, timeout);
        checks++;
        if (miss !== 1'b0 || rdata !== 32'h23000001) begin
            failures++;
            $display("[TB] FAIL snoop_other: miss=%b data=%h expected 0/23000001", miss, rdata);
        end
        cpu_read(32'h53, 2, 32'h53535353, 1, rdata, miss, saddr, lat, timeout);
        checks++;
        if (timeout || miss !== 1'b1 || rdata !== 32'h53535353) begin
            failures++;
            $display("[TB] FAIL snoop_fill_data: miss=%b data=%h expected 1/53535353", miss, rdata);
        end
        cpu_read(32'h53, 0, 32'h53000002, 0, rdata, miss, saddr, lat, timeout);
        checks++;
        if (miss !== 1'b1 || rdata !== 32'h53000002) begin
            failures++;
            $display("[TB] FAIL snoop_fill_kill: miss=%b data=%h expected 1/53000002", miss, rdata);
        end
        cpu_read(32'h63, 2, 32'h63636363, 2, rdata, miss, saddr, lat, timeout);
        cpu_read(32'h63, 0, 32'h63000002, 0, rdata, miss, saddr, lat, timeout);
        checks++;
        if (miss !== 1'b1 || rdata !== 32'h63000002) begin
            failures++;
            $display("[TB] FAIL snoop_busreq_kill: miss=%b data=%h expected 1/63000002", miss, rdata);
        end
    endtask

    task automatic test_grant_stall_and_reset();
        logic [31:0] rdata, saddr;
        logic miss, timeout;
        int lat;
        bit bad;
        do_reset();
        cpu_read(32'h07, 0, 32'h07070707, 0, rdata, miss, saddr, lat, timeout);
        cpu_read(32'h07, 0, 32'h0, 0, rdata, miss, saddr, lat, timeout);
        cpu_addr = 32'h99; cpu_rd = 1;
        @(posedge clk); #1;
        cpu_rd = 0;
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_req !== 1'b1 || cpu_stall !== 1'b1 || cpu_valid !== 1'b0 || bus_rd !== 1'b0) bad = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("[TB] FAIL gnt_stall: req/stall/valid/rd wrong while grant withheld, now %b%b%b%b expected 1100",
                     bus_req, cpu_stall, cpu_valid, bus_rd);
        end
        bus_gnt = 1;
        @(posedge clk); #1;
        checks++;
        if (bus_rd !== 1'b1 || bus_addr !== 32'h99) begin
            failures++;
            $display("[TB] FAIL gnt_fill: bus_rd=%b bus_addr=%h expected 1/99", bus_rd, bus_addr);
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0; bus_gnt = 0;
        model_reset();
        checks++;
        if ({bus_req, bus_rd, cpu_stall} !== 3'b000 || hit_count !== 4'd0 || miss_count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL rst_fill: req/rd/stall=%b hits=%0d misses=%0d expected 000/0/0",
                     {bus_req, bus_rd, cpu_stall}, hit_count, miss_count);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (cpu_valid !== 1'b0 || bus_req !== 1'b0) bad = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("[TB] FAIL rst_quiet: cpu_valid or bus_req seen after reset, now %b%b expected 00", cpu_valid, bus_req);
        end
        cpu_read(32'h07, 1, 32'h07000007, 0, rdata, miss, saddr, lat, timeout);
        checks++;
        if (miss !== 1'b1 || rdata !== 32'h07000007) begin
            failures++;
            $display("[TB] FAIL rst_cold: miss=%b data=%h expected 1/07000007", miss, rdata);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] rdata, saddr;
        logic miss, timeout;
        int lat;
        bit bad = 0;
        do_reset();
        cpu_read(32'h05, 0, 32'h05050505, 0, rdata, miss, saddr, lat, timeout);
        for (int i = 1; i <= 17; i++) begin
            cpu_read(32'h05, 0, 32'h0, 0, rdata, miss, saddr, lat, timeout);
            if (miss !== 1'b0 || rdata !== 32'h05050505) bad = 1;
            if (i == 14) begin
                checks++;
                if (hit_count !== 4'd14) begin
                    failures++;
                    $display("[TB] FAIL sat_pre: hits=%0d expected 14", hit_count);
                end
            end
        end
        checks++;
        if (bad) begin
            failures++;
            $display("[TB] FAIL sat_hits: a repeated read did not hit with data 05050505, last %b/%h", miss, rdata);
        end
        checks++;
        if (hit_count !== 4'd15 || miss_count !== 4'd1) begin
            failures++;
            $display("[TB] FAIL sat_count: hits=%0d misses=%0d expected 15/1", hit_count, miss_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdata, saddr;
        logic miss, timeout;
        int lat;
        do_reset();
        cpu_read(32'h0C, 0, 32'hC0C0C0C0, 0, rdata, miss, saddr, lat, timeout);
        cpu_read(32'h1D, 0, 32'hD1D1D1D1, 0, rdata, miss, saddr, lat, timeout);
        for (int i = 0; i < 4; i++) begin
            cpu_read((i % 2 == 0) ? 32'h0C : 32'h1D, 0, 32'h0, 0, rdata, miss, saddr, lat, timeout);
            checks++;
            if (timeout || lat != 2 || rdata !== ((i % 2 == 0) ? 32'hC0C0C0C0 : 32'hD1D1D1D1)) begin
                failures++;
                $display("[TB] FAIL b2b_%0d: timeout=%b lat=%0d data=%h expected 0/2/%h",
                         i, timeout, lat, rdata, (i % 2 == 0) ? 32'hC0C0C0C0 : 32'hD1D1D1D1);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, fill, rdata, saddr, exp_data, tagv, iaddr;
        logic miss, timeout, exp_miss;
        int gw, mode, lat, exp_lat;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                tagv  = 32'($urandom_range(0, 5));
                iaddr = {tagv[27:0], 4'h3};
                snoop(iaddr);
                model_inv(iaddr);
            end
            tagv = 32'($urandom_range(0, 5));
            addr = {tagv[27:0], ($urandom_range(0, 1) == 1) ? 4'h3 : 4'hA};
            gw   = int'($urandom_range(0, 3));
            mode = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            fill = $urandom;
            model_read(addr, fill, mode != 0, exp_data, exp_miss);
            exp_lat = exp_miss ? 4 + gw : 2;
            cpu_read(addr, gw, fill, mode, rdata, miss, saddr, lat, timeout);
            checks++;
            if (timeout || rdata !== exp_data || miss !== exp_miss || lat != exp_lat) begin
                failures++;
                $display("[TB] FAIL rand%0d: addr=%h timeout=%b data=%h miss=%b lat=%0d expected data=%h miss=%b lat=%0d",
                         n, addr, timeout, rdata, miss, lat, exp_data, exp_miss, exp_lat);
            end
            checks++;
            if (hit_count !== 4'(m_hits) || miss_count !== 4'(m_misses)) begin
                failures++;
                $display("[TB] FAIL rand%0d_count: hits=%0d misses=%0d expected %0d/%0d",
                         n, hit_count, miss_count, m_hits, m_misses);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss_then_hit();
        test_lru();
        test_snoop();
        test_grant_stall_and_reset();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
